// File: rtl/ren_pkg.sv
// Shared types for the rename unit: default widths, the registered rename
// result and a packed RAT snapshot.
package ren_pkg;

    localparam int REN_ARCH_REGS = 32;
    localparam int REN_PHYS_REGS = 64;
    localparam int REN_NUM_CKPT  = 4;

    localparam int REN_AREG_W = $clog2(REN_ARCH_REGS);
    localparam int REN_PTAG_W = $clog2(REN_PHYS_REGS);
    localparam int REN_CKPT_W = $clog2(REN_NUM_CKPT);

    typedef logic [REN_PTAG_W-1:0] ptag_t;
    typedef logic [REN_AREG_W-1:0] areg_t;
    typedef logic [REN_CKPT_W-1:0] ckptId_t;

    typedef struct packed {
        ptag_t   pdest;
        ptag_t   oldPdest;
        ptag_t   ps1;
        ptag_t   ps2;
        ckptId_t ckptId;
        logic    ckptValid;
    } renResult_t;

    typedef logic [REN_ARCH_REGS-1:0][REN_PTAG_W-1:0] ratSnap_t;

endpackage

// File: rtl/ren_freelist.sv
// Circular buffer of free physical tags. Pointers carry an extra wrap bit so
// that tail - head gives the exact number of free tags, including "all free".
module ren_freelist
    import ren_pkg::*;
#(
    parameter int ARCH_REGS = REN_ARCH_REGS,
    parameter int PHYS_REGS = REN_PHYS_REGS,
    localparam int PTAG_W   = $clog2(PHYS_REGS),
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS,
    localparam int FL_W     = $clog2(FL_DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              popReq,
    input  logic              pushReq,
    input  logic [PTAG_W-1:0] pushData,
    input  logic              restoreReq,
    input  logic [FL_W:0]     restoreHead,
    output logic [FL_W:0]     headPtr,
    output logic [PTAG_W-1:0] popData,
    output logic [PTAG_W:0]   freeCount
);

    logic [PTAG_W-1:0] fl [FL_DEPTH];
    logic [FL_W:0]     head;
    logic [FL_W:0]     tail;
    logic [FL_W:0]     count;
    logic              full;

    // Occupancy and the tag at the head are pure functions of the pointers.
    always_comb begin
        count     = tail - head;
        full      = (count == (FL_W+1)'(FL_DEPTH));
        headPtr   = head;
        popData   = fl[head[FL_W-1:0]];
        freeCount = (PTAG_W+1)'(count);
    end

    // Commit pushes append at the tail; a push into a full list is dropped.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int j = 0; j < FL_DEPTH; j++) begin
                fl[j] <= PTAG_W'(ARCH_REGS + j);
            end
            tail <= (FL_W+1)'(FL_DEPTH);
        end else if (pushReq && !full) begin
            fl[tail[FL_W-1:0]] <= pushData;
            tail               <= tail + 1'b1;
        end
    end

    // The head either rewinds to a checkpointed value or advances on a pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head <= '0;
        end else if (restoreReq) begin
            head <= restoreHead;
        end else if (popReq) begin
            head <= head + 1'b1;
        end
    end

endmodule

// File: rtl/ren_ckpt_map.sv
// Single-issue rename stage: RAT lookup, tag allocation from the free list,
// and branch checkpoints of RAT plus free-list head for one-cycle recovery.
module ren_ckpt_map
    import ren_pkg::*;
#(
    parameter int ARCH_REGS = REN_ARCH_REGS,
    parameter int PHYS_REGS = REN_PHYS_REGS,
    parameter int NUM_CKPT  = REN_NUM_CKPT,
    localparam int AREG_W   = $clog2(ARCH_REGS),
    localparam int PTAG_W   = $clog2(PHYS_REGS),
    localparam int CKPT_W   = $clog2(NUM_CKPT),
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS,
    localparam int FL_W     = $clog2(FL_DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FREEZE,
    input  logic              ren_valid_IN,
    output logic              ren_ready_OUT,
    input  logic              ren_destReqd_IN,
    input  logic              ren_isBranch_IN,
    input  logic [AREG_W-1:0] ren_dest_IN,
    input  logic [AREG_W-1:0] ren_src1_IN,
    input  logic [AREG_W-1:0] ren_src2_IN,
    output logic              out_valid_OUT,
    output logic [PTAG_W-1:0] out_pdest_OUT,
    output logic [PTAG_W-1:0] out_oldPdest_OUT,
    output logic [PTAG_W-1:0] out_ps1_OUT,
    output logic [PTAG_W-1:0] out_ps2_OUT,
    output logic              out_ckptValid_OUT,
    output logic [CKPT_W-1:0] out_ckptId_OUT,
    input  logic              tFreeL_pushReq_IN,
    input  logic [PTAG_W-1:0] tFreeL_pushData_IN,
    input  logic              recover_IN,
    input  logic [CKPT_W-1:0] recoverCkpt_IN,
    input  logic              ckptRelease_IN,
    output logic [PTAG_W:0]   freeCount_OUT
);

    logic [PTAG_W-1:0] rat      [ARCH_REGS];
    logic [PTAG_W-1:0] ratNext  [ARCH_REGS];
    logic [PTAG_W-1:0] snapRat  [NUM_CKPT][ARCH_REGS];
    logic [FL_W:0]     snapHead [NUM_CKPT];

    logic [CKPT_W:0]   ckHead;
    logic [CKPT_W:0]   ckTail;
    logic [CKPT_W:0]   ckCount;
    logic [CKPT_W:0]   ckTailRestore;
    logic [CKPT_W-1:0] ckOffset;
    logic              ckFull;

    logic              destEff;
    logic              accept;
    logic              popReq;
    logic [PTAG_W-1:0] popData;
    logic [FL_W:0]     flHead;
    logic [FL_W:0]     headAfterPop;
    logic [PTAG_W:0]   freeCount;

    renResult_t        resNext;
    renResult_t        resQ;
    logic              outValidQ;

    ren_freelist #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_freelist (
        .CLK         (CLK),
        .RESET       (RESET),
        .popReq      (popReq),
        .pushReq     (tFreeL_pushReq_IN),
        .pushData    (tFreeL_pushData_IN),
        .restoreReq  (recover_IN),
        .restoreHead (snapHead[recoverCkpt_IN]),
        .headPtr     (flHead),
        .popData     (popData),
        .freeCount   (freeCount)
    );

    // Handshake, checkpoint occupancy and the ckTail value that keeps slot k live after recovery.
    always_comb begin
        destEff       = ren_destReqd_IN && (ren_dest_IN != '0);
        ckCount       = ckTail - ckHead;
        ckFull        = (ckCount == (CKPT_W+1)'(NUM_CKPT));
        ren_ready_OUT = !FREEZE && !recover_IN
                        && ((freeCount != '0) || !destEff)
                        && (!ckFull || !ren_isBranch_IN);
        accept        = ren_valid_IN && ren_ready_OUT;
        popReq        = accept && destEff;
        headAfterPop  = flHead + (FL_W+1)'(popReq);
        ckOffset      = recoverCkpt_IN - ckHead[CKPT_W-1:0];
        ckTailRestore = ckHead + {1'b0, ckOffset} + (CKPT_W+1)'(1);
    end

    // Next RAT includes this instruction's write so a branch snapshot captures it.
    always_comb begin
        ratNext = rat;
        if (popReq) begin
            ratNext[ren_dest_IN] = popData;
        end
    end

    // Rename result; register 0 is forced to tag 0 on every read.
    always_comb begin
        resNext           = '0;
        resNext.ps1       = (ren_src1_IN == '0) ? '0 : REN_PTAG_W'(rat[ren_src1_IN]);
        resNext.ps2       = (ren_src2_IN == '0) ? '0 : REN_PTAG_W'(rat[ren_src2_IN]);
        resNext.ckptValid = ren_isBranch_IN;
        resNext.ckptId    = REN_CKPT_W'(ckTail[CKPT_W-1:0]);
        if (destEff) begin
            resNext.pdest    = REN_PTAG_W'(popData);
            resNext.oldPdest = REN_PTAG_W'(rat[ren_dest_IN]);
        end
    end

    // RAT: identity after reset, restored from a snapshot on recovery.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= PTAG_W'(i);
            end
        end else if (recover_IN) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= snapRat[recoverCkpt_IN][i];
            end
        end else begin
            rat <= ratNext;
        end
    end

    // Checkpoint ring: branches allocate at ckTail, releases retire ckHead, recovery trims the tail.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ckHead <= '0;
            ckTail <= '0;
            for (int c = 0; c < NUM_CKPT; c++) begin
                snapHead[c] <= '0;
                for (int i = 0; i < ARCH_REGS; i++) begin
                    snapRat[c][i] <= '0;
                end
            end
        end else if (recover_IN) begin
            ckTail <= ckTailRestore;
        end else begin
            if (accept && ren_isBranch_IN) begin
                snapRat[ckTail[CKPT_W-1:0]]  <= ratNext;
                snapHead[ckTail[CKPT_W-1:0]] <= headAfterPop;
                ckTail                       <= ckTail + 1'b1;
            end
            if (ckptRelease_IN && (ckCount != '0)) begin
                ckHead <= ckHead + 1'b1;
            end
        end
    end

    // One-cycle output register; valid only in the cycle after an accept.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            outValidQ <= 1'b0;
            resQ      <= '0;
        end else begin
            outValidQ <= accept;
            if (accept) begin
                resQ <= resNext;
            end
        end
    end

    // Drive ports from the registered result.
    always_comb begin
        out_valid_OUT     = outValidQ;
        out_pdest_OUT     = PTAG_W'(resQ.pdest);
        out_oldPdest_OUT  = PTAG_W'(resQ.oldPdest);
        out_ps1_OUT       = PTAG_W'(resQ.ps1);
        out_ps2_OUT       = PTAG_W'(resQ.ps2);
        out_ckptValid_OUT = outValidQ && resQ.ckptValid;
        out_ckptId_OUT    = CKPT_W'(resQ.ckptId);
        freeCount_OUT     = freeCount;
    end

endmodule

// File: tb/tb_ren_ckpt_map.sv
// Directed bench for ren_ckpt_map with an expected-result queue.
module tb_ren_ckpt_map;

    localparam int AREG_W = 5;
    localparam int PTAG_W = 6;
    localparam int CKPT_W = 2;

    typedef struct {
        int pdest;
        int oldPdest;
        int ps1;
        int ps2;
        int ckptValid;
        int ckptId;
    } exp_t;

    logic              CLK;
    logic              RESET;
    logic              FREEZE;
    logic              ren_valid_IN;
    logic              ren_ready_OUT;
    logic              ren_destReqd_IN;
    logic              ren_isBranch_IN;
    logic [AREG_W-1:0] ren_dest_IN;
    logic [AREG_W-1:0] ren_src1_IN;
    logic [AREG_W-1:0] ren_src2_IN;
    logic              out_valid_OUT;
    logic [PTAG_W-1:0] out_pdest_OUT;
    logic [PTAG_W-1:0] out_oldPdest_OUT;
    logic [PTAG_W-1:0] out_ps1_OUT;
    logic [PTAG_W-1:0] out_ps2_OUT;
    logic              out_ckptValid_OUT;
    logic [CKPT_W-1:0] out_ckptId_OUT;
    logic              tFreeL_pushReq_IN;
    logic [PTAG_W-1:0] tFreeL_pushData_IN;
    logic              recover_IN;
    logic [CKPT_W-1:0] recoverCkpt_IN;
    logic              ckptRelease_IN;
    logic [PTAG_W:0]   freeCount_OUT;

    int   testsRun;
    int   failCount;
    exp_t expQ[$];

    ren_ckpt_map dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .FREEZE             (FREEZE),
        .ren_valid_IN       (ren_valid_IN),
        .ren_ready_OUT      (ren_ready_OUT),
        .ren_destReqd_IN    (ren_destReqd_IN),
        .ren_isBranch_IN    (ren_isBranch_IN),
        .ren_dest_IN        (ren_dest_IN),
        .ren_src1_IN        (ren_src1_IN),
        .ren_src2_IN        (ren_src2_IN),
        .out_valid_OUT      (out_valid_OUT),
        .out_pdest_OUT      (out_pdest_OUT),
        .out_oldPdest_OUT   (out_oldPdest_OUT),
        .out_ps1_OUT        (out_ps1_OUT),
        .out_ps2_OUT        (out_ps2_OUT),
        .out_ckptValid_OUT  (out_ckptValid_OUT),
        .out_ckptId_OUT     (out_ckptId_OUT),
        .tFreeL_pushReq_IN  (tFreeL_pushReq_IN),
        .tFreeL_pushData_IN (tFreeL_pushData_IN),
        .recover_IN         (recover_IN),
        .recoverCkpt_IN     (recoverCkpt_IN),
        .ckptRelease_IN     (ckptRelease_IN),
        .freeCount_OUT      (freeCount_OUT)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        FREEZE             = 1'b0;
        ren_valid_IN       = 1'b0;
        ren_destReqd_IN    = 1'b0;
        ren_isBranch_IN    = 1'b0;
        ren_dest_IN        = '0;
        ren_src1_IN        = '0;
        ren_src2_IN        = '0;
        tFreeL_pushReq_IN  = 1'b0;
        tFreeL_pushData_IN = '0;
        recover_IN         = 1'b0;
        recoverCkpt_IN     = '0;
        ckptRelease_IN     = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        RESET = 1'b0;
        stepClock();
        stepClock();
        RESET = 1'b1;
    endtask

    task automatic offer(input int destReqd, input int dest, input int s1, input int s2, input int br);
        ren_valid_IN    = 1'b1;
        ren_destReqd_IN = (destReqd != 0);
        ren_isBranch_IN = (br != 0);
        ren_dest_IN     = AREG_W'(dest);
        ren_src1_IN     = AREG_W'(s1);
        ren_src2_IN     = AREG_W'(s2);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, ".valid"}, 32'(out_valid_OUT), 1);
            check({tag, ".pdest"}, 32'(out_pdest_OUT), e.pdest);
            check({tag, ".oldPdest"}, 32'(out_oldPdest_OUT), e.oldPdest);
            check({tag, ".ps1"}, 32'(out_ps1_OUT), e.ps1);
            check({tag, ".ps2"}, 32'(out_ps2_OUT), e.ps2);
            check({tag, ".ckptValid"}, 32'(out_ckptValid_OUT), e.ckptValid);
            if (e.ckptValid != 0) begin
                check({tag, ".ckptId"}, 32'(out_ckptId_OUT), e.ckptId);
            end
        end else begin
            check({tag, ".validLow"}, 32'(out_valid_OUT), 0);
        end
    endtask

    task automatic applyStimulus(input string tag, input int destReqd, input int dest,
                                 input int s1, input int s2, input int br,
                                 input int ePdest, input int eOld, input int ePs1,
                                 input int ePs2, input int eCkId);
        exp_t e;
        offer(destReqd, dest, s1, s2, br);
        #1;
        check({tag, ".ready"}, 32'(ren_ready_OUT), 1);
        e.pdest     = ePdest;
        e.oldPdest  = eOld;
        e.ps1       = ePs1;
        e.ps2       = ePs2;
        e.ckptValid = br;
        e.ckptId    = eCkId;
        expQ.push_back(e);
        stepClock();
        idleInputs();
        checkOutput(tag);
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        doReset();

        check("reset.valid", 32'(out_valid_OUT), 0);
        check("reset.pdest", 32'(out_pdest_OUT), 0);
        check("reset.freeCount", 32'(freeCount_OUT), 32);
        check("reset.ready", 32'(ren_ready_OUT), 1);

        offer(1, 3, 1, 2, 0);
        FREEZE = 1'b1;
        #1;
        check("freeze.ready", 32'(ren_ready_OUT), 0);
        FREEZE = 1'b0;
        applyStimulus("add", 1, 3, 1, 2, 0, 32, 3, 1, 2, 0);
        check("add.freeCount", 32'(freeCount_OUT), 31);

        for (int i = 1; i < 32; i++) begin
            applyStimulus($sformatf("fill%0d", i), 1, 7, 7, 0, 0,
                          32 + i, (i == 1) ? 7 : 31 + i, (i == 1) ? 7 : 31 + i, 0, 0);
        end
        check("fill.freeCount", 32'(freeCount_OUT), 0);

        offer(1, 8, 3, 7, 0);
        #1;
        check("empty.ready", 32'(ren_ready_OUT), 0);
        tFreeL_pushReq_IN  = 1'b1;
        tFreeL_pushData_IN = 6'd3;
        stepClock();
        tFreeL_pushReq_IN = 1'b0;
        checkOutput("emptyStall");
        check("push.freeCount", 32'(freeCount_OUT), 1);
        applyStimulus("afterPush", 1, 8, 3, 7, 0, 3, 8, 32, 63, 0);
        check("afterPush.freeCount", 32'(freeCount_OUT), 0);

        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("r9_%0d", i), 1, 9, 0, 0, 0, 32 + i, (i == 0) ? 9 : 31 + i, 0, 0, 0);
        end
        applyStimulus("br0", 1, 5, 5, 0, 1, 40, 5, 5, 0, 0);
        applyStimulus("r5b", 1, 5, 5, 0, 0, 41, 40, 40, 0, 0);
        applyStimulus("r6", 1, 6, 5, 6, 0, 42, 6, 41, 6, 0);
        offer(1, 10, 5, 6, 0);
        recover_IN     = 1'b1;
        recoverCkpt_IN = 2'd0;
        #1;
        check("recover.ready", 32'(ren_ready_OUT), 0);
        stepClock();
        idleInputs();
        checkOutput("recover0");
        check("recover0.freeCount", 32'(freeCount_OUT), 23);
        applyStimulus("postRec", 1, 10, 5, 6, 0, 41, 10, 40, 6, 0);
        check("postRec.freeCount", 32'(freeCount_OUT), 22);

        applyStimulus("br1", 0, 0, 10, 5, 1, 0, 0, 41, 40, 1);
        applyStimulus("br2", 0, 0, 10, 5, 1, 0, 0, 41, 40, 2);
        applyStimulus("br3", 0, 0, 10, 5, 1, 0, 0, 41, 40, 3);
        offer(0, 0, 10, 5, 1);
        #1;
        check("ckFull.ready", 32'(ren_ready_OUT), 0);
        ckptRelease_IN = 1'b1;
        stepClock();
        ckptRelease_IN = 1'b0;
        idleInputs();
        checkOutput("release");
        applyStimulus("brWrap", 0, 0, 10, 5, 1, 0, 0, 41, 40, 0);

        applyStimulus("r11", 1, 11, 0, 0, 0, 42, 11, 0, 0, 0);
        check("r11.freeCount", 32'(freeCount_OUT), 21);
        recover_IN         = 1'b1;
        recoverCkpt_IN     = 2'd1;
        tFreeL_pushReq_IN  = 1'b1;
        tFreeL_pushData_IN = 6'd5;
        stepClock();
        idleInputs();
        checkOutput("recPush");
        check("recPush.freeCount", 32'(freeCount_OUT), 23);
        applyStimulus("r12", 1, 12, 11, 10, 0, 42, 12, 11, 41, 0);
        check("r12.freeCount", 32'(freeCount_OUT), 22);
        applyStimulus("dest0", 1, 0, 12, 0, 0, 0, 0, 42, 0, 0);
        check("dest0.freeCount", 32'(freeCount_OUT), 22);

        applyStimulus("r13", 1, 13, 12, 0, 0, 43, 13, 42, 0, 0);
        #2;
        RESET = 1'b0;
        #1;
        check("midReset.valid", 32'(out_valid_OUT), 0);
        check("midReset.pdest", 32'(out_pdest_OUT), 0);
        check("midReset.ps1", 32'(out_ps1_OUT), 0);
        check("midReset.oldPdest", 32'(out_oldPdest_OUT), 0);
        check("midReset.freeCount", 32'(freeCount_OUT), 32);
        RESET = 1'b1;
        applyStimulus("identity", 1, 4, 12, 11, 0, 32, 4, 12, 11, 0);
        check("identity.freeCount", 32'(freeCount_OUT), 31);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
